// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_rr block.
//   state_e   : arbitration FSM state (waiting for a grant / locked to a packet)
//   sel_width : width of a channel index for a given channel count
package stream_mux_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } state_e;

  // Channel-index width; never below 1 so ports stay legal for tiny configurations.
  function automatic int unsigned sel_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req cyclically starting at the channel just after ptr and returns the
// first requester, both as a one-hot vector and as an index. No requester gives an
// all-zero grant and index 0.
//   req   in  NUM_CH  request per channel
//   ptr   in  SEL_W   last granted channel (search starts at ptr+1)
//   grant out NUM_CH  one-hot grant
//   index out SEL_W   index of the granted channel
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned  NUM_CH = 4,
  localparam int unsigned SEL_W  = sel_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  index
);

  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    index = '0;
    cand  = '0;
    found = 1'b0;
    // i runs 1..NUM_CH so ptr itself is visited last.
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = SEL_W'((32'(ptr) + i) % NUM_CH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 packet-preserving stream multiplexer with a registered output stage.
// A channel is chosen while idle (round-robin for MODE=0, external sel for MODE=1),
// then the mux stays locked to it until the beat carrying s_last is accepted.
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   s_data/s_valid/s_last       per-channel input streams (channel i at slice i)
//   s_ready                     per-channel accept, only the locked channel may see 1
//   sel                         channel select, only used when MODE=1
//   m_data/m_valid/m_last/m_chan registered output beat and its source channel
//   m_ready                     downstream accept
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  NUM_CH     = 4,
  parameter int unsigned  MODE       = 0,
  localparam int unsigned SEL_W      = sel_width(NUM_CH)
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_CH-1:0]            s_valid,
  input  logic [NUM_CH-1:0]            s_last,
  output logic [NUM_CH-1:0]            s_ready,
  input  logic [SEL_W-1:0]             sel,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  output logic                         m_last,
  output logic [SEL_W-1:0]             m_chan,
  input  logic                         m_ready
);

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      grant_q, grant_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [SEL_W-1:0]      m_chan_q, m_chan_d;

  logic                  pick_valid;
  logic [SEL_W-1:0]      pick_idx;
  logic                  cur_valid, cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  out_free;
  logic                  accept;

  // Candidate channel for the next grant, evaluated only while idle.
  if (MODE == 0) begin : g_rr
    logic [NUM_CH-1:0] arb_grant;
    logic              unused_sel;

    rr_arbiter #(
      .NUM_CH (NUM_CH)
    ) u_arb (
      .req   (s_valid),
      .ptr   (rr_ptr_q),
      .grant (arb_grant),
      .index (pick_idx)
    );

    assign pick_valid = |arb_grant;
    assign unused_sel = ^sel;
  end else begin : g_sel
    logic unused_rr_ptr;

    // Out-of-range sel matches no channel, so the FSM simply stays idle.
    always_comb begin
      pick_valid = 1'b0;
      pick_idx   = sel;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (sel == SEL_W'(c) && s_valid[c]) begin
          pick_valid = 1'b1;
        end
      end
    end

    assign unused_rr_ptr = ^rr_ptr_q;
  end

  // Source mux driven only by the registered grant.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_q == SEL_W'(c)) begin
        cur_valid = s_valid[c];
        cur_last  = s_last[c];
        cur_data  = s_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_free = !m_valid_q || m_ready;
  assign accept   = (state_q == StLocked) && cur_valid && out_free;

  always_comb begin
    s_ready = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      s_ready[c] = (state_q == StLocked) && (grant_q == SEL_W'(c)) && out_free;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_chan_d  = m_chan_q;

    // A pending beat leaves on m_ready; a newly accepted beat below overrides this.
    if (m_ready) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (accept) begin
          m_data_d  = cur_data;
          m_valid_d = 1'b1;
          m_last_d  = cur_last;
          m_chan_d  = grant_q;
          if (cur_last) begin
            state_d  = StIdle;
            rr_ptr_d = grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_ptr_q  <= SEL_W'(NUM_CH - 1);
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_chan_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_chan_q  <= m_chan_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_chan  = m_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a round-robin instance (4 channels) and a select-mode
// instance (5 channels, so out-of-range sel values are representable).
module tb_stream_mux_rr;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int          chan;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk;
  logic rst0_n, rst1_n;

  // Round-robin instance
  logic [127:0] s_data0;
  logic [3:0]   s_valid0, s_last0, s_ready0;
  logic [1:0]   sel0;
  logic [31:0]  m_data0;
  logic         m_valid0, m_last0, m_ready0;
  logic [1:0]   m_chan0;

  // Select-mode instance
  logic [79:0]  s_data1;
  logic [4:0]   s_valid1, s_last1, s_ready1;
  logic [2:0]   sel1;
  logic [15:0]  m_data1;
  logic         m_valid1, m_last1, m_ready1;
  logic [2:0]   m_chan1;

  stream_mux_rr #(
    .DATA_WIDTH (32),
    .NUM_CH     (4),
    .MODE       (0)
  ) dut0 (
    .sys_clk   (clk),
    .sys_rst_n (rst0_n),
    .s_data    (s_data0),
    .s_valid   (s_valid0),
    .s_last    (s_last0),
    .s_ready   (s_ready0),
    .sel       (sel0),
    .m_data    (m_data0),
    .m_valid   (m_valid0),
    .m_last    (m_last0),
    .m_chan    (m_chan0),
    .m_ready   (m_ready0)
  );

  stream_mux_rr #(
    .DATA_WIDTH (16),
    .NUM_CH     (5),
    .MODE       (1)
  ) dut1 (
    .sys_clk   (clk),
    .sys_rst_n (rst1_n),
    .s_data    (s_data1),
    .s_valid   (s_valid1),
    .s_last    (s_last1),
    .s_ready   (s_ready1),
    .sel       (sel1),
    .m_data    (m_data1),
    .m_valid   (m_valid1),
    .m_last    (m_last1),
    .m_chan    (m_chan1),
    .m_ready   (m_ready1)
  );

  int checks = 0;
  int errors = 0;

  beat_t ch_q0[4][$];
  beat_t mdl_q0[4][$];
  exp_t  exp0[$];
  beat_t ch_q1[5][$];
  exp_t  exp1[$];

  int    mdl_ptr  = 3;  // last granted channel in the reference model
  int    rdy_mode = 0;  // 0: m_ready=1, 1: 1,0,0,1 pattern, 2: random
  bit    gaps_on  = 0;  // random s_valid drops inside a packet
  int    epoch0   = 0;  // bumped on mid-run reset so the monitor forgets held beats
  bit    bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic add_pkt0(input int c, input int len, input int base, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? $urandom : 32'(base + i);
      b.last = (i == len - 1);
      ch_q0[c].push_back(b);
      mdl_q0[c].push_back(b);
    end
  endtask

  task automatic add_pkt1(input int c, input int len, input int base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = 32'(base + i);
      b.last = (i == len - 1);
      ch_q1[c].push_back(b);
    end
  endtask

  // Whole-packet round-robin: the next channel after the last winner that still
  // has a packet takes its entire packet, then becomes the new pointer.
  task automatic model_run0();
    bit    done = 0;
    beat_t b;
    exp_t  e;
    while (!done) begin
      int pick = -1;
      for (int i = 1; i <= 4; i++) begin
        if (pick < 0 && mdl_q0[(mdl_ptr + i) % 4].size() > 0) pick = (mdl_ptr + i) % 4;
      end
      if (pick < 0) begin
        done = 1;
      end else begin
        do begin
          b = mdl_q0[pick].pop_front();
          e.chan = pick;
          e.data = b.data;
          e.last = b.last;
          exp0.push_back(e);
        end while (!b.last);
        mdl_ptr = pick;
      end
    end
  endtask

  function automatic bit busy0();
    return (ch_q0[0].size() + ch_q0[1].size() + ch_q0[2].size() + ch_q0[3].size()) != 0;
  endfunction

  task automatic drain0(input string name);
    int n = 0;
    while ((exp0.size() != 0 || busy0()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(exp0.size() == 0 && !busy0(), {name, " drain"}, exp0.size(), 0);
  endtask

  // Driver for the round-robin instance: advances per-channel queues on accepted beats.
  logic [3:0] fire0;
  bit         mid_pkt0[4];
  int         bp_i = 0;
  initial begin
    s_valid0 = '0;
    s_last0  = '0;
    s_data0  = '0;
    m_ready0 = 1'b1;
    sel0     = '0;
    forever begin
      @(negedge clk);
      fire0 = s_valid0 & s_ready0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (fire0[c] && ch_q0[c].size() > 0) begin
          mid_pkt0[c] = !ch_q0[c][0].last;
          void'(ch_q0[c].pop_front());
        end
        if (ch_q0[c].size() == 0) mid_pkt0[c] = 0;
        if (ch_q0[c].size() > 0 && !(mid_pkt0[c] && gaps_on && $urandom_range(2) == 0)) begin
          s_valid0[c]          = 1'b1;
          s_data0[c*32 +: 32] = ch_q0[c][0].data;
          s_last0[c]           = ch_q0[c][0].last;
        end else begin
          s_valid0[c]          = 1'b0;
          s_data0[c*32 +: 32] = $urandom;
          s_last0[c]           = 1'($urandom_range(1));
        end
      end
      sel0 = 2'($urandom_range(3));
      case (rdy_mode)
        1: begin
          m_ready0 = bp_pat[bp_i % 4];
          bp_i++;
        end
        2: m_ready0 = 1'($urandom_range(1));
        default: m_ready0 = 1'b1;
      endcase
    end
  end

  // Driver for the select-mode instance.
  logic [4:0] fire1;
  initial begin
    s_valid1 = '0;
    s_last1  = '0;
    s_data1  = '0;
    m_ready1 = 1'b1;
    forever begin
      @(negedge clk);
      fire1 = s_valid1 & s_ready1;
      @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
        if (fire1[c] && ch_q1[c].size() > 0) void'(ch_q1[c].pop_front());
        if (ch_q1[c].size() > 0) begin
          s_valid1[c]          = 1'b1;
          s_data1[c*16 +: 16] = ch_q1[c][0].data[15:0];
          s_last1[c]           = ch_q1[c][0].last;
        end else begin
          s_valid1[c]          = 1'b0;
          s_data1[c*16 +: 16] = 16'($urandom);
          s_last1[c]           = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard for the round-robin instance.
  initial begin
    exp_t        e;
    bit          hold_v = 0;
    logic [31:0] hold_d = '0;
    logic        hold_l = 0;
    logic [1:0]  hold_c = '0;
    int          seen_epoch = 0;
    forever begin
      @(negedge clk);
      if (seen_epoch != epoch0) begin
        hold_v     = 0;
        seen_epoch = epoch0;
      end
      if (rst0_n) begin
        chk($countones(s_ready0) <= 1, "s_ready0 onehot", s_ready0, 0);
        if (hold_v) begin
          chk(m_valid0 && m_data0 == hold_d && m_last0 == hold_l && m_chan0 == hold_c,
              "m_data hold", m_data0, hold_d);
        end
        if (m_valid0 && m_ready0) begin
          hold_v = 0;
          if (exp0.size() == 0) begin
            chk(0, "unexpected beat0", m_data0, 0);
          end else begin
            e = exp0.pop_front();
            chk(m_chan0 == 2'(e.chan), "m_chan0", m_chan0, e.chan);
            chk(m_data0 == e.data, "m_data0", m_data0, e.data);
            chk(m_last0 == e.last, "m_last0", m_last0, e.last);
          end
        end else begin
          hold_v = m_valid0;
          hold_d = m_data0;
          hold_l = m_last0;
          hold_c = m_chan0;
        end
      end
    end
  end

  // Monitor / scoreboard for the select-mode instance (m_ready1 held high).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst1_n && m_valid1 && m_ready1) begin
        if (exp1.size() == 0) begin
          chk(0, "unexpected beat1", m_data1, 0);
        end else begin
          e = exp1.pop_front();
          chk(m_chan1 == 3'(e.chan), "m_chan1", m_chan1, e.chan);
          chk(m_data1 == e.data[15:0], "m_data1", m_data1, e.data);
          chk(m_last1 == e.last, "m_last1", m_last1, e.last);
        end
      end
    end
  end

  task automatic push_exp1(input int c, input int data, input bit last);
    exp_t e;
    e.chan = c;
    e.data = 32'(data);
    e.last = last;
    exp1.push_back(e);
  endtask

  initial begin
    int n;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    sel1   = 3'd5;

    // Reset with every channel valid: nothing may be accepted or presented.
    for (int c = 0; c < 4; c++) add_pkt0(c, 1, c * 16, 0);
    for (int c = 0; c < 4; c++) add_pkt0(c, 1, c * 16 + 1, 0);
    add_pkt1(0, 1, 16'hA0);
    add_pkt1(1, 1, 16'hB0);
    add_pkt1(2, 3, 16'hC0);
    add_pkt1(3, 1, 16'hD0);
    add_pkt1(4, 1, 16'hE0);
    repeat (5) begin
      @(negedge clk);
      chk(m_valid0 == 1'b0, "reset m_valid0", m_valid0, 0);
      chk(s_ready0 == '0, "reset s_ready0", s_ready0, 0);
      chk(m_chan0 == '0, "reset m_chan0", m_chan0, 0);
      chk(m_valid1 == 1'b0 && s_ready1 == '0, "reset dut1", {m_valid1, s_ready1}, 0);
    end
    chk(m_data0 == '0 && m_last0 == 1'b0, "reset m_data0/m_last0", m_data0, 0);
    #1;
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    // Fairness with single-beat packets: 0,1,2,3,0,1,2,3.
    model_run0();
    drain0("rr fairness");

    // Packet lock: ch1 3-beat packet must not be split by ch2.
    @(negedge clk);
    add_pkt0(1, 3, 32'h21, 0);
    add_pkt0(2, 1, 32'h30, 0);
    model_run0();
    drain0("packet lock");

    // Back-pressure on a 4-beat packet.
    @(negedge clk);
    rdy_mode = 1;
    add_pkt0(0, 4, 32'h10, 0);
    model_run0();
    drain0("backpressure");
    rdy_mode = 0;

    // Random packets, random m_ready, random valid gaps mid-packet.
    @(negedge clk);
    gaps_on  = 1;
    rdy_mode = 2;
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 4; p++) add_pkt0(c, 1 + $urandom_range(3), 0, 1);
    end
    model_run0();
    drain0("random");
    gaps_on  = 0;
    rdy_mode = 0;

    // Asynchronous reset in the middle of a ch2 packet.
    @(negedge clk);
    add_pkt0(2, 6, 32'h200, 0);
    model_run0();
    n = 0;
    while (ch_q0[2].size() > 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(ch_q0[2].size() <= 4, "mid-packet reached", ch_q0[2].size(), 4);
    #1;
    rst0_n = 1'b0;
    #1;
    chk(m_valid0 == 1'b0, "async reset m_valid0", m_valid0, 0);
    chk(s_ready0 == '0, "async reset s_ready0", s_ready0, 0);
    for (int c = 0; c < 4; c++) ch_q0[c].delete();
    exp0.delete();
    epoch0++;
    mdl_ptr = 3;
    @(posedge clk);
    #2;
    rst0_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) add_pkt0(c, 1, 32'h300 + c, 0);
    model_run0();
    drain0("post reset");

    // Select mode: sel=5 is out of range for 5 channels, so no grant.
    repeat (6) begin
      @(negedge clk);
      chk(m_valid1 == 1'b0 && s_ready1 == '0, "sel out of range idle",
          {m_valid1, s_ready1}, 0);
    end
    push_exp1(2, 16'hC0, 0);
    push_exp1(2, 16'hC1, 0);
    push_exp1(2, 16'hC2, 1);
    push_exp1(0, 16'hA0, 1);
    sel1 = 3'd2;
    n = 0;
    while (ch_q1[2].size() == 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(ch_q1[2].size() < 3, "sel=2 granted", ch_q1[2].size(), 2);
    sel1 = 3'd0;  // must not disturb the locked ch2 packet
    n = 0;
    while (exp1.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(exp1.size() == 0, "mode1 drain", exp1.size(), 0);
    sel1 = 3'd5;
    repeat (6) begin
      @(negedge clk);
      chk(m_valid1 == 1'b0 && s_ready1 == '0, "sel=5 stays idle", {m_valid1, s_ready1}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
